// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: sequencing control for the TPU datapath.
// Takes host commands over a valid/ready handshake and drives registered
// enables for memA, memB and the systolic array. It runs a full matmul
// on its own for a fixed cycle count. It also streams C back to the host
// in LANES-word beats, row by row, and honours host backpressure.
module tpu_seq_ctrl #(
    parameter int unsigned DIM       = 8,
    parameter int unsigned LANES     = 4,
    parameter int unsigned IDXW      = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int unsigned SELW      = ((DIM / LANES) > 1) ? $clog2(DIM / LANES) : 1,
    parameter int unsigned MM_CYCLES = 3 * DIM - 2
) (
    input  logic            clk,
    input  logic            rst_n,

    // host command channel
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [IDXW-1:0] cmd_idx,
    input  logic [SELW-1:0] cmd_sel,
    input  logic            abort,

    // status
    output logic            busy,
    output logic            done,
    output logic            err,

    // memory / array controls
    output logic            memA_en,
    output logic            memA_wren,
    output logic [IDXW-1:0] memA_row,
    output logic            memB_en,
    output logic            sys_en,
    output logic            sys_wren,
    output logic [IDXW-1:0] sys_row,
    output logic [SELW-1:0] sys_sel,

    // C read-back stream
    output logic            rd_valid,
    input  logic            rd_ready
);

    localparam int unsigned BEATS = DIM / LANES;
    localparam int unsigned CNTW  = (MM_CYCLES > 1) ? $clog2(MM_CYCLES) : 1;

    localparam logic [CNTW-1:0] MM_LAST  = CNTW'(MM_CYCLES - 1);
    localparam logic [IDXW-1:0] ROW_LAST = IDXW'(DIM - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(BEATS - 1);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_WRITEA  = 3'd1;
    localparam logic [2:0] OP_WRITEB  = 3'd2;
    localparam logic [2:0] OP_WRITEC  = 3'd3;
    localparam logic [2:0] OP_MATMUL  = 3'd4;
    localparam logic [2:0] OP_READC   = 3'd5;
    localparam logic [2:0] OP_STEP    = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDXW-1:0] beat_row_q, beat_row_d;
    logic [SELW-1:0] beat_sel_q, beat_sel_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            mema_en_q, mema_en_d;
    logic            mema_wren_q, mema_wren_d;
    logic [IDXW-1:0] mema_row_q, mema_row_d;
    logic            memb_en_q, memb_en_d;
    logic            sys_en_q, sys_en_d;
    logic            sys_wren_q, sys_wren_d;
    logic [IDXW-1:0] sys_row_q, sys_row_d;
    logic [SELW-1:0] sys_sel_q, sys_sel_d;
    logic            rd_valid_q, rd_valid_d;

    logic accept;
    logic idx_ok;
    logic last_beat;

    // Abort in IDLE only blocks acceptance; it never reaches the FSM there.
    assign cmd_ready = (state_q == ST_IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    // Only reachable when DIM is not a power of two.
    assign idx_ok    = (32'(cmd_idx) < DIM);
    assign last_beat = (beat_row_q == ROW_LAST) && (beat_sel_q == SEL_LAST);

    // Next-state and next-output decode; every enable defaults low so a
    // single-cycle op pulses for exactly one cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_row_d  = beat_row_q;
        beat_sel_d  = beat_sel_q;
        err_d       = err_q;
        done_d      = 1'b0;
        mema_en_d   = 1'b0;
        mema_wren_d = 1'b0;
        mema_row_d  = '0;
        memb_en_d   = 1'b0;
        sys_en_d    = 1'b0;
        sys_wren_d  = 1'b0;
        sys_row_d   = '0;
        sys_sel_d   = '0;
        rd_valid_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITEA: begin
                            if (idx_ok) begin
                                mema_en_d   = 1'b1;
                                mema_wren_d = 1'b1;
                                mema_row_d  = cmd_idx;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_WRITEB: begin
                            memb_en_d = 1'b1;
                        end
                        OP_WRITEC: begin
                            if (idx_ok) begin
                                sys_en_d   = 1'b1;
                                sys_wren_d = 1'b1;
                                sys_row_d  = cmd_idx;
                                sys_sel_d  = cmd_sel;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_MATMUL: begin
                            state_d   = ST_RUN;
                            cnt_d     = '0;
                            mema_en_d = 1'b1;
                            memb_en_d = 1'b1;
                            sys_en_d  = 1'b1;
                        end
                        OP_READC: begin
                            state_d    = ST_READ;
                            beat_row_d = '0;
                            beat_sel_d = '0;
                            rd_valid_d = 1'b1;
                        end
                        OP_STEP: begin
                            mema_en_d = 1'b1;
                            memb_en_d = 1'b1;
                            sys_en_d  = 1'b1;
                        end
                        OP_ILLEGAL: begin
                            err_d = 1'b1;
                        end
                        default: begin
                            // OP_NOP: handshake only
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == MM_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    mema_en_d = 1'b1;
                    memb_en_d = 1'b1;
                    sys_en_d  = 1'b1;
                end
            end

            ST_READ: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    beat_row_d = '0;
                    beat_sel_d = '0;
                end else if (rd_valid_q && rd_ready) begin
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        beat_row_d = '0;
                        beat_sel_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        // sel is the fast index, row wraps after SEL_LAST
                        if (beat_sel_q == SEL_LAST) begin
                            beat_sel_d = '0;
                            beat_row_d = beat_row_q + 1'b1;
                        end else begin
                            beat_sel_d = beat_sel_q + 1'b1;
                        end
                        rd_valid_d = 1'b1;
                    end
                end else begin
                    rd_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The read address follows the beat counter for as long as a beat is on offer.
        if (rd_valid_d) begin
            sys_row_d = beat_row_d;
            sys_sel_d = beat_sel_d;
        end
    end

    // State and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            beat_row_q  <= '0;
            beat_sel_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            mema_en_q   <= 1'b0;
            mema_wren_q <= 1'b0;
            mema_row_q  <= '0;
            memb_en_q   <= 1'b0;
            sys_en_q    <= 1'b0;
            sys_wren_q  <= 1'b0;
            sys_row_q   <= '0;
            sys_sel_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_row_q  <= beat_row_d;
            beat_sel_q  <= beat_sel_d;
            err_q       <= err_d;
            done_q      <= done_d;
            mema_en_q   <= mema_en_d;
            mema_wren_q <= mema_wren_d;
            mema_row_q  <= mema_row_d;
            memb_en_q   <= memb_en_d;
            sys_en_q    <= sys_en_d;
            sys_wren_q  <= sys_wren_d;
            sys_row_q   <= sys_row_d;
            sys_sel_q   <= sys_sel_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign memA_en   = mema_en_q;
    assign memA_wren = mema_wren_q;
    assign memA_row  = mema_row_q;
    assign memB_en   = memb_en_q;
    assign sys_en    = sys_en_q;
    assign sys_wren  = sys_wren_q;
    assign sys_row   = sys_row_q;
    assign sys_sel   = sys_sel_q;
    assign rd_valid  = rd_valid_q;

endmodule
